// File: rtl/gf_pkg.sv
// Shared types and defaults for the GF(2^M) arithmetic controller and its
// bit-serial multiplier.
package gf_pkg;

    localparam int GF_M_DEFAULT    = 6;
    localparam int GF_POLY_DEFAULT = 'h43;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_SQR = 2'b01,
        OP_INV = 2'b10,
        OP_DIV = 2'b11
    } gf_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LAUNCH = 2'b01,
        WAIT   = 2'b10,
        DONE   = 2'b11
    } gf_state_t;

    // Index of the final multiply step of an operation (steps count from 0).
    function automatic logic [3:0] gf_last_step(input gf_op_t op, input int m);
        logic [3:0] last;
        case (op)
            OP_INV:  last = 4'(2 * m - 4);
            OP_DIV:  last = 4'(2 * m - 3);
            default: last = 4'd0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/gf_mul_seq.sv
// Bit-serial MSB-first interleaved GF(2^M) multiplier: the first partial
// product is folded in on the start edge, so p is ready M cycles after start.
module gf_mul_seq
    import gf_pkg::*;
#(
    parameter int M    = GF_M_DEFAULT,
    parameter int POLY = GF_POLY_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] p,
    output logic         done
);

    localparam logic [M-1:0] POLY_LO = M'(POLY);

    logic [M-1:0] r_a;
    logic [M-1:0] r_b;
    logic [M-1:0] r_acc;
    logic [3:0]   r_cnt;
    logic         r_done;
    logic [M-1:0] w_acc_next;

    // acc*x mod POLY, then conditionally add a for the current multiplier bit.
    assign w_acc_next = {r_acc[M-2:0], 1'b0}
                      ^ ({M{r_acc[M-1]}} & POLY_LO)
                      ^ ({M{r_b[M-1]}} & r_a);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_a   <= a;
                r_b   <= {b[M-2:0], 1'b0};
                r_acc <= b[M-1] ? a : '0;
                r_cnt <= 4'(M - 1);
            end else if (r_cnt != 4'd0) begin
                r_acc <= w_acc_next;
                r_b   <= {r_b[M-2:0], 1'b0};
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign p    = r_acc;
    assign done = r_done;

endmodule

// File: rtl/gf_alu_controller.sv
// GF(2^M) ALU: MUL, SQR, INV and DIV built from a sequence of multiply steps
// on one shared bit-serial multiplier, with a valid/ready request and result.
module gf_alu_controller
    import gf_pkg::*;
#(
    parameter int M    = GF_M_DEFAULT,
    parameter int POLY = GF_POLY_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [M-1:0] x,
    input  logic [M-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] z,
    output logic         err,
    output logic         busy
);

    gf_state_t    r_state;
    gf_op_t       r_op;
    logic [M-1:0] r_x;
    logic [M-1:0] r_y;
    logic [M-1:0] r_res;
    logic [M-1:0] r_z;
    logic [3:0]   r_step;
    logic         r_phase;
    logic         r_zero;
    logic         r_err;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_busy;

    logic         w_start;
    logic [M-1:0] w_mul_b;
    logic [M-1:0] w_mul_p;
    logic         w_mul_done;
    logic [3:0]   w_last;
    gf_op_t       w_op_in;
    logic         w_zero_in;

    assign w_op_in = gf_op_t'(op);
    assign w_start = (r_state == LAUNCH);
    assign w_last  = gf_last_step(r_op, M);

    // Inversion of zero still runs the whole chain so latency never depends on data.
    always_comb begin
        w_zero_in = 1'b0;
        case (w_op_in)
            OP_INV:  w_zero_in = (x == '0);
            OP_DIV:  w_zero_in = (y == '0);
            default: w_zero_in = 1'b0;
        endcase
    end

    // Operand a is always the running result; b picks square, base or final x.
    always_comb begin
        w_mul_b = r_res;
        case (r_op)
            OP_MUL:  w_mul_b = r_y;
            OP_SQR:  w_mul_b = r_res;
            OP_INV:  w_mul_b = r_phase ? r_x : r_res;
            OP_DIV:  w_mul_b = (r_step == w_last) ? r_x : (r_phase ? r_y : r_res);
            default: w_mul_b = r_res;
        endcase
    end

    gf_mul_seq #(
        .M    (M),
        .POLY (POLY)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .a     (r_res),
        .b     (w_mul_b),
        .p     (w_mul_p),
        .done  (w_mul_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op        <= OP_MUL;
            r_x         <= '0;
            r_y         <= '0;
            r_res       <= '0;
            r_z         <= '0;
            r_step      <= '0;
            r_phase     <= 1'b0;
            r_zero      <= 1'b0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op       <= w_op_in;
                        r_x        <= x;
                        r_y        <= y;
                        r_res      <= (w_op_in == OP_DIV) ? y : x;
                        r_step     <= '0;
                        r_phase    <= 1'b0;
                        r_zero     <= w_zero_in;
                        r_state    <= LAUNCH;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                LAUNCH: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (w_mul_done) begin
                        r_res <= w_mul_p;
                        if (r_step == w_last) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_z         <= r_zero ? '0 : w_mul_p;
                            r_err       <= r_zero;
                        end else begin
                            r_step  <= r_step + 4'd1;
                            r_phase <= ~r_phase;
                            r_state <= LAUNCH;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign z         = r_z;
    assign err       = r_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_gf_alu_controller.sv
// Self-checking bench for gf_alu_controller at M=6 (0x43) and M=4 (0x13).
module tb_gf_alu_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] xd;
    logic [5:0] yd;
    logic       iv6, or6, iv4, or4;
    logic       ir6, ov6, err6, busy6;
    logic       ir4, ov4, err4, busy4;
    logic [5:0] z6;
    logic [3:0] z4;

    int total = 0;
    int bad = 0;
    int acc6 = 0;
    int n_issued6 = 0;

    always #5 clk = ~clk;

    gf_alu_controller #(.M(6), .POLY('h43)) u_dut6 (
        .clk(clk), .reset(reset), .in_valid(iv6), .in_ready(ir6), .op(op),
        .x(xd), .y(yd), .out_valid(ov6), .out_ready(or6), .z(z6),
        .err(err6), .busy(busy6)
    );

    gf_alu_controller #(.M(4), .POLY('h13)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .op(op),
        .x(xd[3:0]), .y(yd[3:0]), .out_valid(ov4), .out_ready(or4), .z(z4),
        .err(err4), .busy(busy4)
    );

    always @(posedge clk) begin
        if (!reset && iv6 && ir6) acc6 <= acc6 + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model: field arithmetic ----------------
    function automatic int gmul(input int m, input int poly, input int a, input int b);
        int prod = 0;
        for (int i = 0; i < m; i++) if ((b >> i) & 1) prod ^= (a << i);
        for (int i = 2 * m - 2; i >= m; i--) if ((prod >> i) & 1) prod ^= (poly << (i - m));
        return prod;
    endfunction

    function automatic int ginv(input int m, input int poly, input int a);
        for (int c = 1; c < (1 << m); c++) if (gmul(m, poly, a, c) == 1) return c;
        return 0;
    endfunction

    function automatic int exp_err(input int o, input int a, input int b);
        if (o == 2) return (a == 0) ? 1 : 0;
        if (o == 3) return (b == 0) ? 1 : 0;
        return 0;
    endfunction

    function automatic int exp_z(input int m, input int poly, input int o, input int a, input int b);
        case (o)
            0: return gmul(m, poly, a, b);
            1: return gmul(m, poly, a, a);
            2: return ginv(m, poly, a);
            default: return (b == 0) ? 0 : gmul(m, poly, a, ginv(m, poly, b));
        endcase
    endfunction

    function automatic int exp_lat(input int m, input int o);
        int steps;
        steps = (o < 2) ? 1 : ((o == 2) ? 2 * m - 3 : 2 * m - 2);
        return steps * (m + 1) + 1;
    endfunction

    // ---------------- per-instance accessors ----------------
    function automatic bit g_ov(input bit s);   return s ? ov4 : ov6;     endfunction
    function automatic bit g_ir(input bit s);   return s ? ir4 : ir6;     endfunction
    function automatic bit g_busy(input bit s); return s ? busy4 : busy6; endfunction
    function automatic bit g_err(input bit s);  return s ? err4 : err6;   endfunction
    function automatic int g_z(input bit s);    return s ? int'(z4) : int'(z6); endfunction

    task automatic set_iv(input bit s, input bit v);
        if (s) iv4 = v; else iv6 = v;
    endtask

    task automatic set_or(input bit s, input bit v);
        if (s) or4 = v; else or6 = v;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns at #1 after the accept edge, i.e. in cycle 1 of the operation.
    task automatic start_op(input bit s, input logic [1:0] o, input int xa, input int ya, input bit keep);
        int t;
        @(negedge clk);
        op = o;
        xd = xa[5:0];
        yd = ya[5:0];
        set_iv(s, 1'b1);
        t = 0;
        while (!g_ir(s) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) chk("accept_timeout", 0, 1);
        if (!s) n_issued6++;
        @(posedge clk);
        #1;
        if (!keep) set_iv(s, 1'b0);
    endtask

    task automatic wait_result(input bit s, output int lat, output int zr, output int er);
        int cur;
        cur = 1;
        while (!g_ov(s) && cur < 400) begin
            @(posedge clk);
            #1;
            cur++;
        end
        lat = g_ov(s) ? cur : -1;
        zr  = g_z(s);
        er  = int'(g_err(s));
    endtask

    task automatic hold_check(input bit s, input int n, input int zr, input int er);
        for (int h = 0; h < n; h++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", int'(g_ov(s)), 1);
            chk("hold_z", g_z(s), zr);
            chk("hold_err", int'(g_err(s)), er);
            chk("hold_in_ready", int'(g_ir(s)), 0);
        end
    endtask

    task automatic release_out(input bit s);
        set_or(s, 1'b1);
        @(posedge clk);
        #1;
        set_or(s, 1'b0);
        chk("release_valid", int'(g_ov(s)), 0);
        chk("release_in_ready", int'(g_ir(s)), 1);
    endtask

    task automatic run_op(input bit s, input logic [1:0] o, input int xa, input int ya,
                          input int hold, output int lat, output int zr, output int er);
        start_op(s, o, xa, ya, 1'b0);
        wait_result(s, lat, zr, er);
        hold_check(s, hold, zr, er);
        release_out(s);
    endtask

    typedef struct {
        bit         sel;
        logic [1:0] op;
        int         x;
        int         y;
        int         z;
        int         e;
        int         lat;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int lat, zr, er, zi, seen, cur, m, poly;
        logic [1:0] o;
        int xa, ya, hold;

        tbl[0]  = '{1'b0, 2'b00, 'h02, 'h20, 'h03, 0, 8};
        tbl[1]  = '{1'b0, 2'b10, 'h02, 'h00, 'h21, 0, 64};
        tbl[2]  = '{1'b0, 2'b10, 'h00, 'h00, 'h00, 1, 64};
        tbl[3]  = '{1'b0, 2'b11, 'h03, 'h02, 'h20, 0, 71};
        tbl[4]  = '{1'b0, 2'b01, 'h2A, 'h00, 'h37, 0, 8};
        tbl[5]  = '{1'b0, 2'b00, 'h2A, 'h01, 'h2A, 0, 8};
        tbl[6]  = '{1'b0, 2'b11, 'h15, 'h00, 'h00, 1, 71};
        tbl[7]  = '{1'b0, 2'b00, 'h3F, 'h00, 'h00, 0, 8};
        tbl[8]  = '{1'b0, 2'b01, 'h2A, 'h15, 'h37, 0, 8};
        tbl[9]  = '{1'b1, 2'b00, 'h2, 'h8, 'h3, 0, 6};
        tbl[10] = '{1'b1, 2'b10, 'h2, 'h0, 'h9, 0, 26};
        tbl[11] = '{1'b1, 2'b11, 'h3, 'h2, 'h8, 0, 31};

        reset = 1'b1;
        iv6 = 1'b0; or6 = 1'b0; iv4 = 1'b0; or4 = 1'b0;
        op = 2'b00; xd = '0; yd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(ir6), 1);
        chk("rst_out_valid", int'(ov6), 0);
        chk("rst_z", int'(z6), 0);
        chk("rst_err", int'(err6), 0);
        chk("rst_busy", int'(busy6), 0);
        chk("rst_in_ready_m4", int'(ir4), 1);
        chk("rst_busy_m4", int'(busy4), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].sel, tbl[i].op, tbl[i].x, tbl[i].y, 0, lat, zr, er);
            $display("vec %0d m=%0d op=%0d x=0x%0h y=0x%0h -> z=0x%0h err=%0d lat=%0d",
                     i, tbl[i].sel ? 4 : 6, tbl[i].op, tbl[i].x, tbl[i].y, zr, er, lat);
            chk("vec_lat", lat, tbl[i].lat);
            chk("vec_z", zr, tbl[i].z);
            chk("vec_err", er, tbl[i].e);
        end

        for (int i = 0; i < 40; i++) begin
            bit s;
            s    = ($urandom_range(0, 3) == 0);
            m    = s ? 4 : 6;
            poly = s ? 'h13 : 'h43;
            o    = 2'($urandom_range(0, 3));
            xa   = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, (1 << m) - 1));
            ya   = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, (1 << m) - 1));
            hold = int'($urandom_range(0, 2));
            run_op(s, o, xa, ya, hold, lat, zr, er);
            $display("rnd %0d m=%0d op=%0d x=0x%0h y=0x%0h -> z=0x%0h err=%0d lat=%0d",
                     i, m, o, xa, ya, zr, er, lat);
            chk("rnd_lat", lat, exp_lat(m, int'(o)));
            chk("rnd_z", zr, exp_z(m, poly, int'(o), xa, ya));
            chk("rnd_err", er, exp_err(int'(o), xa, ya));
        end

        for (int xv = 1; xv < 16; xv++) begin
            run_op(1'b1, 2'b10, xv, 0, 0, lat, zi, er);
            chk("m4_inv_lat", lat, 26);
            chk("m4_inv_model", zi, ginv(4, 'h13, xv));
            run_op(1'b1, 2'b00, xv, zi, 0, lat, zr, er);
            $display("m4 x=0x%0h inv=0x%0h x*inv=0x%0h", xv, zi, zr);
            chk("m4_x_times_inv", zr, 1);
        end

        // Stall in DONE, then a back-to-back request with in_valid held high.
        start_op(1'b0, 2'b00, 'h02, 'h20, 1'b0);
        wait_result(1'b0, lat, zr, er);
        chk("b2b_first_lat", lat, 8);
        chk("b2b_first_z", zr, 'h03);
        hold_check(1'b0, 5, 'h03, 0);
        op = 2'b01; xd = 6'h2A; yd = 6'h00;
        iv6 = 1'b1;
        or6 = 1'b1;
        @(posedge clk);
        #1;
        or6 = 1'b0;
        chk("b2b_idle_ready", int'(ir6), 1);
        chk("b2b_idle_valid", int'(ov6), 0);
        @(posedge clk);
        #1;
        n_issued6++;
        chk("b2b_accept_ready", int'(ir6), 0);
        chk("b2b_accept_busy", int'(busy6), 1);
        wait_result(1'b0, lat, zr, er);
        $display("b2b sqr 0x2A -> z=0x%0h lat=%0d", zr, lat);
        chk("b2b_second_lat", lat, 8);
        chk("b2b_second_z", zr, 'h37);
        or6 = 1'b1;
        @(posedge clk);
        #1;
        or6 = 1'b0;
        @(posedge clk);
        #1;
        n_issued6++;
        iv6 = 1'b0;
        chk("b2b_third_ready", int'(ir6), 0);
        wait_result(1'b0, lat, zr, er);
        chk("b2b_third_lat", lat, 8);
        release_out(1'b0);

        // Abort an INV at cycle 20 with reset, then a fresh MUL.
        start_op(1'b0, 2'b10, 'h05, 0, 1'b0);
        cur = 1;
        while (cur < 20) begin
            @(posedge clk);
            #1;
            cur++;
        end
        reset = 1'b1;
        #1;
        chk("midrst_in_ready", int'(ir6), 1);
        chk("midrst_out_valid", int'(ov6), 0);
        chk("midrst_z", int'(z6), 0);
        chk("midrst_err", int'(err6), 0);
        chk("midrst_busy", int'(busy6), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (90) begin
            @(posedge clk);
            #1;
            if (ov6) seen++;
        end
        chk("midrst_stale_valid", seen, 0);
        run_op(1'b0, 2'b00, 'h02, 'h20, 0, lat, zr, er);
        $display("post-reset mul 0x02*0x20 -> z=0x%0h lat=%0d", zr, lat);
        chk("midrst_mul_lat", lat, 8);
        chk("midrst_mul_z", zr, 'h03);

        @(posedge clk);
        #1;
        chk("accept_count", acc6, n_issued6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
